hazard_unit: RTL

//  Consumer side of the pipelined control path: tracks the control/destination bits that decode emits through E, M and W,
//  and drives stall, flush and forwarding selects back into the datapath. Detects RAW hazards (forwarding), load-use

---
 rtl/hazard_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks E/M/W control bits and drives stall, flush and forwarding
// selects, plus saturating stall/flush event counters.
module hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] WriteRegD,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             PCSrcM,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  logic [REG_W-1:0] rs_e_r, rt_e_r, wr_e_r, wr_m_r, wr_w_r;
  logic             regwrite_e_r, memtoreg_e_r;
  logic             regwrite_m_r, memtoreg_m_r;
  logic             regwrite_w_r;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;
  logic             lwstall_s;

  // M wins over W; register 0 never forwards. Loads in M are excluded by the load-use stall.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic             rw_m,
    input logic [REG_W-1:0] wr_m,
    input logic             rw_w,
    input logic [REG_W-1:0] wr_w
  );
    logic [1:0] sel;
    if (rw_m && (wr_m != {REG_W{1'b0}}) && (wr_m == src)) begin
      sel = 2'b10;
    end else if (rw_w && (wr_w != {REG_W{1'b0}}) && (wr_w == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Load-use hazard: load in E whose destination feeds the instruction in D.
  always_comb begin
    lwstall_s = memtoreg_e_r && regwrite_e_r && (wr_e_r != {REG_W{1'b0}}) &&
                ((wr_e_r == RsD) || (wr_e_r == RtD));
  end

  // Stage registers and saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs_e_r       <= {REG_W{1'b0}};
      rt_e_r       <= {REG_W{1'b0}};
      wr_e_r       <= {REG_W{1'b0}};
      regwrite_e_r <= 1'b0;
      memtoreg_e_r <= 1'b0;
      wr_m_r       <= {REG_W{1'b0}};
      regwrite_m_r <= 1'b0;
      memtoreg_m_r <= 1'b0;
      wr_w_r       <= {REG_W{1'b0}};
      regwrite_w_r <= 1'b0;
      stall_cnt_r  <= {CNT_W{1'b0}};
      flush_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (PCSrcM || lwstall_s) begin
        rs_e_r       <= {REG_W{1'b0}};
        rt_e_r       <= {REG_W{1'b0}};
        wr_e_r       <= {REG_W{1'b0}};
        regwrite_e_r <= 1'b0;
        memtoreg_e_r <= 1'b0;
      end else begin
        rs_e_r       <= RsD;
        rt_e_r       <= RtD;
        wr_e_r       <= WriteRegD;
        regwrite_e_r <= RegWriteD;
        memtoreg_e_r <= MemtoRegD;
      end
      if (PCSrcM) begin
        wr_m_r       <= {REG_W{1'b0}};
        regwrite_m_r <= 1'b0;
        memtoreg_m_r <= 1'b0;
      end else begin
        wr_m_r       <= wr_e_r;
        regwrite_m_r <= regwrite_e_r;
        memtoreg_m_r <= memtoreg_e_r;
      end
      wr_w_r       <= wr_m_r;
      regwrite_w_r <= regwrite_m_r;
      if (lwstall_s && !PCSrcM && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (PCSrcM && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  // Output decode; a taken branch overrides a load-use stall, and reset forces all outputs low.
  always_comb begin
    StallF      = 1'b0;
    StallD      = 1'b0;
    FlushD      = 1'b0;
    FlushE      = 1'b0;
    FlushM      = 1'b0;
    ForwardAE   = 2'b00;
    ForwardBE   = 2'b00;
    stall_count = {CNT_W{1'b0}};
    flush_count = {CNT_W{1'b0}};
    if (reset) begin
      StallF = 1'b0;
    end else begin
      if (PCSrcM) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
        FlushM = 1'b1;
      end else if (lwstall_s) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else begin
        FlushE = 1'b0;
      end
      ForwardAE   = fwd_sel(rs_e_r, regwrite_m_r, wr_m_r, regwrite_w_r, wr_w_r);
      ForwardBE   = fwd_sel(rt_e_r, regwrite_m_r, wr_m_r, regwrite_w_r, wr_w_r);
      stall_count = stall_cnt_r;
      flush_count = flush_cnt_r;
    end
  end

endmodule
